bus_demux: RTL

BUS_DEMUX -- requirements
Module: bus_demux

---
 rtl/bus_demux_pkg.sv | 24 ++
 rtl/bus_demux_if.sv | 12 +
 rtl/bus_demux_slot.sv | 56 +++++
 rtl/bus_demux.sv | 61 ++++++
 4 files changed

// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the two-channel bus demultiplexer.
package bus_demux_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NUM_CH     = 2;
   localparam int CNT_W      = 8;

   // Channel index; channel 0 is the default route.
   typedef logic [0:0] ch_idx_t;
   localparam ch_idx_t CH0 = 1'b0;
   localparam ch_idx_t CH1 = 1'b1;

   // Per-channel holding FSM.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Channel 1 only for sel = (0,1); every other combination goes to channel 0.
   function automatic ch_idx_t route_ch(input logic ch0_sel, input logic ch1_sel);
      return (!ch0_sel && ch1_sel) ? CH1 : CH0;
   endfunction

endpackage

// File: rtl/bus_demux_if.sv
// Shared write bus: data word, write strobe and channel select bits.
interface bus_demux_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              ch0_sel;
   logic              ch1_sel;

   modport master (output din, din_valid, ch0_sel, ch1_sel);
   modport slave  (input  din, din_valid, ch0_sel, ch1_sel);
endinterface

// File: rtl/bus_demux_slot.sv
// One channel: holding register, EMPTY/FULL FSM, sticky overflow, accept counter.
module demux_slot
   import bus_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ack,
   input  logic              clr_ovf,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              ovf,
   output logic [CNT_W-1:0]  cnt
);

   slot_state_e state;

   // Channel FSM; a set caused by a drop overrides a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SLOT_EMPTY;
         data  <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         if (clr_ovf) ovf <= 1'b0;
         case (state)
            SLOT_EMPTY: begin
               // ack with nothing held is ignored
               if (wr_en) begin
                  state <= SLOT_FULL;
                  data  <= wdata;
                  cnt   <= cnt + 1'b1;
               end
            end
            SLOT_FULL: begin
               if (wr_en && ack) begin
                  data <= wdata;
                  cnt  <= cnt + 1'b1;
               end else if (wr_en) begin
                  ovf <= 1'b1;
               end else if (ack) begin
                  state <= SLOT_EMPTY;
               end
            end
            default: state <= SLOT_EMPTY;
         endcase
      end
   end

   assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/bus_demux.sv
// Routes the shared write bus into one of two channel slots.
module bus_demux
   import bus_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   bus_demux_if.slave        bus,
   input  logic              ch0_ack,
   input  logic              ch1_ack,
   input  logic              clr_ovf,
   output logic [DATA_W-1:0] ch0_data,
   output logic [DATA_W-1:0] ch1_data,
   output logic              ch0_valid,
   output logic              ch1_valid,
   output logic              ch0_ovf,
   output logic              ch1_ovf,
   output logic [CNT_W-1:0]  ch0_cnt,
   output logic [CNT_W-1:0]  ch1_cnt
);

   ch_idx_t                          tgt;
   logic [NUM_CH-1:0]                wr_en;
   logic [NUM_CH-1:0]                ack;
   logic [NUM_CH-1:0][DATA_W-1:0]    data;
   logic [NUM_CH-1:0]                valid;
   logic [NUM_CH-1:0]                ovf;
   logic [NUM_CH-1:0][CNT_W-1:0]     cnt;

   assign tgt = route_ch(bus.ch0_sel, bus.ch1_sel);
   assign ack = {ch1_ack, ch0_ack};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      // Exactly one slot sees the strobe for any write.
      assign wr_en[i] = bus.din_valid && (tgt == ch_idx_t'(i));

      demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[i]),
         .wdata   (bus.din),
         .ack     (ack[i]),
         .clr_ovf (clr_ovf),
         .data    (data[i]),
         .valid   (valid[i]),
         .ovf     (ovf[i]),
         .cnt     (cnt[i])
      );
   end

   assign ch0_data  = data[CH0];
   assign ch1_data  = data[CH1];
   assign ch0_valid = valid[CH0];
   assign ch1_valid = valid[CH1];
   assign ch0_ovf   = ovf[CH0];
   assign ch1_ovf   = ovf[CH1];
   assign ch0_cnt   = cnt[CH0];
   assign ch1_cnt   = cnt[CH1];

endmodule
